// File: rtl/hh_neuron_scheduler_if.sv
// Issue/result channel between the neuron scheduler and the shared HH update datapath.
// The master issues operands on dp_valid/dp_ready; the slave returns results on a res_valid strobe.
interface hh_neuron_scheduler_if #(
  parameter int W  = 16,
  parameter int IW = 2
);
  logic          dp_valid;
  logic          dp_ready;
  logic [IW-1:0] dp_idx;
  logic [W-1:0]  dp_V;
  logic [W-1:0]  dp_m;
  logic [W-1:0]  dp_h;
  logic [W-1:0]  dp_n;
  logic [W-1:0]  dp_I;
  logic [W-1:0]  dp_dt;
  logic          res_valid;
  logic [W-1:0]  res_V;
  logic [W-1:0]  res_m;
  logic [W-1:0]  res_h;
  logic [W-1:0]  res_n;

  modport master (
    output dp_valid, dp_idx, dp_V, dp_m, dp_h, dp_n, dp_I, dp_dt,
    input  dp_ready, res_valid, res_V, res_m, res_h, res_n
  );

  modport slave (
    input  dp_valid, dp_idx, dp_V, dp_m, dp_h, dp_n, dp_I, dp_dt,
    output dp_ready, res_valid, res_V, res_m, res_h, res_n
  );
endinterface

// File: rtl/hh_neuron_scheduler.sv
// Shares one HH datapath across N_NEURONS contexts: per neuron ISSUE -> WAIT -> WB (3 cycles min),
// stalls in ISSUE while dp_ready is low and gives up after TIMEOUT cycles in WAIT.
module hh_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int W         = 16,
  parameter int V_THRESH  = 30,
  parameter int TIMEOUT   = 63,
  localparam int IW       = $clog2(N_NEURONS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  dt,
  input  logic          cur_we,
  input  logic [IW-1:0] cur_addr,
  input  logic [W-1:0]  current_in,
  input  logic [IW-1:0] rd_addr,
  output logic [W-1:0]  data_out,
  hh_neuron_scheduler_if.master dp,
  output logic          busy,
  output logic          step_done,
  output logic          spike_valid,
  output logic [IW-1:0] spike_idx,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]        V_RST = W'(-65);
  localparam logic [W-1:0]        H_RST = W'(1);
  localparam logic signed [W-1:0] VTH   = W'(V_THRESH);
  localparam logic [IW-1:0]       LAST  = IW'(N_NEURONS - 1);
  localparam logic [CW-1:0]       TLIM  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          last;

  logic [W-1:0] ctx_v [N_NEURONS];
  logic [W-1:0] ctx_m [N_NEURONS];
  logic [W-1:0] ctx_h [N_NEURONS];
  logic [W-1:0] ctx_n [N_NEURONS];
  logic [W-1:0] ctx_i [N_NEURONS];

  logic [W-1:0] dt_q;
  logic [W-1:0] op_v, op_m, op_h, op_n, op_i, op_dt;
  logic [W-1:0] cap_v, cap_m, cap_h, cap_n;
  logic         cap_ok;

  assign last    = (idx == LAST);
  assign idx_nxt = idx + 1'b1;
  assign tmo_hit = (state == WAIT) && !dp.res_valid && (tmo_cnt == TLIM);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (dp.dp_ready) state_nxt = WAIT;
      WAIT:    if (dp.res_valid || tmo_hit) state_nxt = WB;
      WB:      state_nxt = last ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dp.dp_valid = (state == ISSUE);
  assign dp.dp_idx   = idx;
  assign dp.dp_V     = op_v;
  assign dp.dp_m     = op_m;
  assign dp.dp_h     = op_h;
  assign dp.dp_n     = op_n;
  assign dp.dp_I     = op_i;
  assign dp.dp_dt    = op_dt;

  assign busy        = (state != IDLE);
  assign step_done   = (state == WB) && last;
  assign spike_idx   = idx;
  // Old V is still in the context during WB; the new value sits in the capture register.
  assign spike_valid = (state == WB) && cap_ok &&
                       ($signed(ctx_v[idx]) < VTH) && ($signed(cap_v) >= VTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        ctx_v[i] <= V_RST;
        ctx_m[i] <= '0;
        ctx_h[i] <= H_RST;
        ctx_n[i] <= '0;
        ctx_i[i] <= '0;
      end
      idx         <= '0;
      tmo_cnt     <= '0;
      dt_q        <= '0;
      op_v        <= '0;
      op_m        <= '0;
      op_h        <= '0;
      op_n        <= '0;
      op_i        <= '0;
      op_dt       <= '0;
      cap_v       <= '0;
      cap_m       <= '0;
      cap_h       <= '0;
      cap_n       <= '0;
      cap_ok      <= 1'b0;
      timeout_err <= 1'b0;
      data_out    <= V_RST;
    end else begin
      if (cur_we) ctx_i[cur_addr] <= current_in;

      case (state)
        IDLE: begin
          if (start) begin
            dt_q        <= dt;
            idx         <= '0;
            timeout_err <= 1'b0;
            op_v        <= ctx_v[0];
            op_m        <= ctx_m[0];
            op_h        <= ctx_h[0];
            op_n        <= ctx_n[0];
            op_i        <= ctx_i[0];
            op_dt       <= dt;
          end
        end
        ISSUE: begin
          if (dp.dp_ready) tmo_cnt <= '0;
        end
        WAIT: begin
          if (dp.res_valid) begin
            cap_v  <= dp.res_V;
            cap_m  <= dp.res_m;
            cap_h  <= dp.res_h;
            cap_n  <= dp.res_n;
            cap_ok <= 1'b1;
          end else if (tmo_hit) begin
            cap_ok      <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WB: begin
          if (cap_ok) begin
            ctx_v[idx] <= cap_v;
            ctx_m[idx] <= cap_m;
            ctx_h[idx] <= cap_h;
            ctx_n[idx] <= cap_n;
          end
          // Operands for the next neuron are frozen here, on entry to ISSUE.
          if (!last) begin
            idx   <= idx_nxt;
            op_v  <= ctx_v[idx_nxt];
            op_m  <= ctx_m[idx_nxt];
            op_h  <= ctx_h[idx_nxt];
            op_n  <= ctx_n[idx_nxt];
            op_i  <= ctx_i[idx_nxt];
            op_dt <= dt_q;
          end
        end
        default: ;
      endcase

      if ((state == WB) && cap_ok && (rd_addr == idx)) data_out <= cap_v;
      else                                             data_out <= ctx_v[rd_addr];
    end
  end

endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// Directed bench for hh_neuron_scheduler: a cycle-driven datapath model inside run_step,
// with one task per scenario checking against hand-computed values.
module tb_hh_neuron_scheduler;

  logic        clock = 1'b0;
  logic        reset, start, cur_we;
  logic [15:0] dt, current_in, data_out;
  logic [1:0]  cur_addr, rd_addr, spike_idx;
  logic        busy, step_done, spike_valid, timeout_err;

  always #5 clock = ~clock;

  hh_neuron_scheduler_if #(.W(16), .IW(2)) dpif ();

  hh_neuron_scheduler #(.N_NEURONS(4), .W(16), .V_THRESH(30), .TIMEOUT(63)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dt         (dt),
    .cur_we     (cur_we),
    .cur_addr   (cur_addr),
    .current_in (current_in),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .dp         (dpif),
    .busy       (busy),
    .step_done  (step_done),
    .spike_valid(spike_valid),
    .spike_idx  (spike_idx),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] ret_v [4];
  int          rdy_delay [4];
  bit          drop_res [4];
  int          poke_we_cyc = -1, poke_start_a = -1, poke_start_b = -1, poke_rst_cyc = -1;
  logic [1:0]  poke_we_addr = 2'd0;
  logic [15:0] poke_we_val = 16'h0;

  int          obs_idx [8];
  int          n_issue, done_cycle, spike_cnt;
  int          spike_at_idx [4];
  int          spike_at_cyc [4];
  logic [15:0] obs_V [4], obs_m [4], obs_h [4], obs_n [4], obs_I [4], obs_dt [4];
  bit          ops_unstable, spike_with_done;
  logic        terr_c1, terr_at_done, rst_valid, rst_busy;

  function automatic logic [97:0] cur_ops();
    return {dpif.dp_idx, dpif.dp_V, dpif.dp_m, dpif.dp_h, dpif.dp_n, dpif.dp_I, dpif.dp_dt};
  endfunction

  task automatic read_v(input logic [1:0] a, output logic [15:0] v);
    rd_addr = a;
    @(posedge clock); #1;
    v = data_out;
  endtask

  // Runs one step from IDLE, acting as the datapath; returns one cycle after step_done (or reset).
  task automatic run_step(input logic [15:0] dtv);
    int          cyc, wcnt;
    bit          give, fin;
    logic [1:0]  gidx;
    logic [97:0] snap;
    n_issue = 0; ops_unstable = 0; done_cycle = -1; spike_cnt = 0; spike_with_done = 0;
    terr_c1 = 1'bx; terr_at_done = 1'bx; rst_valid = 1'bx; rst_busy = 1'bx;
    for (int k = 0; k < 8; k++) obs_idx[k] = -1;
    give = 0; fin = 0; gidx = 2'd0; wcnt = 0; snap = '0;
    start = 1'b1; dt = dtv;
    @(posedge clock); #1;
    cyc = 1;
    while (!fin && cyc < 400) begin
      start      = (cyc == poke_start_a) || (cyc == poke_start_b);
      cur_we     = (cyc == poke_we_cyc);
      cur_addr   = poke_we_addr;
      current_in = poke_we_val;
      reset      = (cyc == poke_rst_cyc);
      dpif.res_valid = give && !drop_res[gidx];
      dpif.res_V = ret_v[gidx];
      dpif.res_m = 16'h1000 | 16'(gidx);
      dpif.res_h = 16'h2000 | 16'(gidx);
      dpif.res_n = 16'h3000 | 16'(gidx);
      give = 0;
      dpif.dp_ready = 1'b0;
      if (cyc == 1) terr_c1 = timeout_err;
      if (dpif.dp_valid) begin
        if (wcnt == 0) begin
          if (n_issue < 8) obs_idx[n_issue] = int'(dpif.dp_idx);
          n_issue++;
          obs_V[dpif.dp_idx]  = dpif.dp_V;
          obs_m[dpif.dp_idx]  = dpif.dp_m;
          obs_h[dpif.dp_idx]  = dpif.dp_h;
          obs_n[dpif.dp_idx]  = dpif.dp_n;
          obs_I[dpif.dp_idx]  = dpif.dp_I;
          obs_dt[dpif.dp_idx] = dpif.dp_dt;
          snap = cur_ops();
        end else if (cur_ops() !== snap) begin
          ops_unstable = 1;
        end
        if (wcnt >= rdy_delay[dpif.dp_idx]) begin
          dpif.dp_ready = 1'b1; give = 1; gidx = dpif.dp_idx; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (spike_valid) begin
        if (spike_cnt < 4) begin
          spike_at_idx[spike_cnt] = int'(spike_idx);
          spike_at_cyc[spike_cnt] = cyc;
        end
        spike_cnt++;
      end
      if (step_done) begin
        done_cycle = cyc; spike_with_done = spike_valid; terr_at_done = timeout_err; fin = 1;
      end
      if (reset) fin = 1;
      @(posedge clock); #1;
      cyc++;
    end
    if (reset) begin
      rst_valid = dpif.dp_valid; rst_busy = busy; reset = 1'b0;
    end
    start = 1'b0; cur_we = 1'b0; dpif.res_valid = 1'b0; dpif.dp_ready = 1'b0;
    poke_we_cyc = -1; poke_start_a = -1; poke_start_b = -1; poke_rst_cyc = -1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1; start = 1'b0; cur_we = 1'b0; dt = '0; current_in = '0; cur_addr = '0; rd_addr = '0;
    dpif.dp_ready = 1'b0; dpif.res_valid = 1'b0;
    dpif.res_V = '0; dpif.res_m = '0; dpif.res_h = '0; dpif.res_n = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    checks++; if (dpif.dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid: got %b want 0", dpif.dp_valid); end
    checks++; if ({step_done, spike_valid, spike_idx} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {step_done, spike_valid, spike_idx}); end
    checks++; if (cur_ops() !== 98'd0) begin errors++; $display("FAIL reset_operands: got %h want 0", cur_ops()); end
    for (int k = 0; k < 4; k++) begin
      read_v(2'(k), got);
      checks++; if (got !== 16'hFFBF) begin errors++; $display("FAIL reset_V%0d: got %h want ffbf", k, got); end
    end
  endtask

  task automatic test_basic_step();
    logic [15:0] got;
    for (int k = 0; k < 4; k++) begin ret_v[k] = 16'hFFC0; rdy_delay[k] = 0; drop_res[k] = 0; end
    run_step(16'd10);
    checks++; if (n_issue !== 4) begin errors++; $display("FAIL basic_issues: got %0d want 4", n_issue); end
    checks++; if (done_cycle !== 12) begin errors++; $display("FAIL basic_done_cycle: got %0d want 12", done_cycle); end
    checks++; if (spike_cnt !== 0) begin errors++; $display("FAIL basic_spikes: got %0d want 0", spike_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_idx[k] !== k) begin errors++; $display("FAIL basic_idx_seq[%0d]: got %0d want %0d", k, obs_idx[k], k); end
      checks++; if ({obs_V[k], obs_h[k], obs_I[k], obs_dt[k]} !== {16'hFFBF, 16'h0001, 16'h0000, 16'd10}) begin
        errors++; $display("FAIL basic_ops%0d: got V=%h h=%h I=%h dt=%h want ffbf 0001 0000 000a", k, obs_V[k], obs_h[k], obs_I[k], obs_dt[k]);
      end
      read_v(2'(k), got);
      checks++; if (got !== 16'hFFC0) begin errors++; $display("FAIL basic_V%0d: got %h want ffc0", k, got); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got;
    for (int k = 0; k < 4; k++) ret_v[k] = 16'hFFC1;
    rdy_delay[2] = 5;
    run_step(16'd7);
    rdy_delay[2] = 0;
    checks++; if (ops_unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got unstable=%b want 0", ops_unstable); end
    checks++; if (done_cycle !== 17) begin errors++; $display("FAIL bp_done_cycle: got %0d want 17", done_cycle); end
    checks++; if (n_issue !== 4) begin errors++; $display("FAIL bp_issues: got %0d want 4", n_issue); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({obs_V[k], obs_m[k], obs_h[k], obs_n[k], obs_dt[k]} !==
                    {16'hFFC0, 16'h1000 | 16'(k), 16'h2000 | 16'(k), 16'h3000 | 16'(k), 16'd7}) begin
        errors++; $display("FAIL bp_ops%0d: got V=%h m=%h h=%h n=%h dt=%h", k, obs_V[k], obs_m[k], obs_h[k], obs_n[k], obs_dt[k]);
      end
      read_v(2'(k), got);
      checks++; if (got !== 16'hFFC1) begin errors++; $display("FAIL bp_V%0d: got %h want ffc1", k, got); end
    end
  endtask

  task automatic test_spike();
    // -63 -> 100 on neuron 0 only spikes under a signed compare.
    ret_v = '{16'h0064, 16'h001D, 16'hFFC1, 16'h001D};
    run_step(16'd1);
    checks++; if ({spike_cnt, spike_at_idx[0], spike_at_cyc[0]} !== {32'd1, 32'd0, 32'd3}) begin
      errors++; $display("FAIL spike_signed: got cnt=%0d idx=%0d cyc=%0d want 1 0 3", spike_cnt, spike_at_idx[0], spike_at_cyc[0]);
    end
    ret_v = '{16'h0064, 16'h001F, 16'hFFC1, 16'h001E};
    run_step(16'd1);
    checks++; if (spike_cnt !== 2) begin errors++; $display("FAIL spike_count: got %0d want 2", spike_cnt); end
    checks++; if ({spike_at_idx[0], spike_at_cyc[0], spike_at_idx[1], spike_at_cyc[1]} !== {32'd1, 32'd6, 32'd3, 32'd12}) begin
      errors++; $display("FAIL spike_events: got %0d@%0d %0d@%0d want 1@6 3@12", spike_at_idx[0], spike_at_cyc[0], spike_at_idx[1], spike_at_cyc[1]);
    end
    checks++; if ({spike_with_done, done_cycle} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL spike_with_done: got %b cyc=%0d want 1 12", spike_with_done, done_cycle);
    end
    ret_v = '{16'h0064, 16'h0028, 16'hFFC1, 16'h0028};
    run_step(16'd1);
    checks++; if (spike_cnt !== 0) begin errors++; $display("FAIL spike_none_above: got %0d want 0", spike_cnt); end
    checks++; if ({obs_V[1], obs_V[3]} !== {16'h001F, 16'h001E}) begin
      errors++; $display("FAIL spike_stored_V: got %h %h want 001f 001e", obs_V[1], obs_V[3]);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] got;
    ret_v = '{16'h0064, 16'h0028, 16'hFFC1, 16'h7777};
    drop_res[3] = 1;
    run_step(16'd2);
    drop_res[3] = 0;
    checks++; if (done_cycle !== 74) begin errors++; $display("FAIL tmo_done_cycle: got %0d want 74", done_cycle); end
    checks++; if ({terr_at_done, timeout_err} !== 2'b11) begin errors++; $display("FAIL tmo_flag: got %b want 11", {terr_at_done, timeout_err}); end
    checks++; if (spike_cnt !== 0) begin errors++; $display("FAIL tmo_spikes: got %0d want 0", spike_cnt); end
    read_v(2'd3, got);
    checks++; if (got !== 16'h0028) begin errors++; $display("FAIL tmo_V3_kept: got %h want 0028", got); end
    read_v(2'd0, got);
    checks++; if (got !== 16'h0064) begin errors++; $display("FAIL tmo_V0: got %h want 0064", got); end
    ret_v = '{16'h0064, 16'h0028, 16'hFFC1, 16'h0028};
    run_step(16'd2);
    checks++; if ({terr_c1, timeout_err} !== 2'b00) begin errors++; $display("FAIL tmo_cleared: got %b want 00", {terr_c1, timeout_err}); end
    checks++; if (done_cycle !== 12) begin errors++; $display("FAIL tmo_next_done: got %0d want 12", done_cycle); end
  endtask

  task automatic test_mid_step();
    logic [15:0] got;
    ret_v = '{16'h0064, 16'h0028, 16'hFFC1, 16'h0028};
    poke_we_cyc = 2; poke_we_addr = 2'd0; poke_we_val = 16'h0055;
    poke_start_a = 5; poke_start_b = 12;
    run_step(16'd3);
    checks++; if (obs_I[0] !== 16'h0000) begin errors++; $display("FAIL mid_I_same_step: got %h want 0000", obs_I[0]); end
    checks++; if (done_cycle !== 12) begin errors++; $display("FAIL mid_busy_start_done: got %0d want 12", done_cycle); end
    checks++; if ({busy, dpif.dp_valid} !== 2'b00) begin errors++; $display("FAIL mid_start_at_done: got %b want 00", {busy, dpif.dp_valid}); end
    run_step(16'd3);
    checks++; if ({obs_I[0], obs_I[1]} !== {16'h0055, 16'h0000}) begin
      errors++; $display("FAIL mid_I_next_step: got %h %h want 0055 0000", obs_I[0], obs_I[1]);
    end
    ret_v = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    poke_rst_cyc = 8;
    run_step(16'd3);
    checks++; if ({rst_valid, rst_busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_outputs: got %b want 00", {rst_valid, rst_busy}); end
    for (int k = 0; k < 4; k++) begin
      read_v(2'(k), got);
      checks++; if (got !== 16'hFFBF) begin errors++; $display("FAIL mid_reset_V%0d: got %h want ffbf", k, got); end
    end
    ret_v = '{16'hFFBF, 16'hFFBF, 16'hFFBF, 16'hFFBF};
    run_step(16'd3);
    checks++; if ({obs_I[0], obs_h[0], obs_m[1], done_cycle} !== {16'h0000, 16'h0001, 16'h0000, 32'd12}) begin
      errors++; $display("FAIL mid_reset_ctx: got I0=%h h0=%h m1=%h done=%0d want 0000 0001 0000 12", obs_I[0], obs_h[0], obs_m[1], done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_backpressure();
    test_spike();
    test_timeout();
    test_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
